// File: rtl/mac_tx_arb_pkg.sv
// Shared definitions for the MAC TX arbiter: state encoding, default inter-frame gap
// and the width of the per-requester completed-frame counters.
package mac_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEGIN = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  localparam int IFG_CYCLES_DEF = 12;
  localparam int FRAME_CNT_W    = 16;

endpackage

// File: rtl/tx_rr_pick.sv
// Combinational round-robin picker: first requester above ptr_i (with wrap) wins,
// so the previous winner sits at lowest priority.
module tx_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             win_vld_o
);

  int   cand;
  logic hit;

  // scan ptr_i+1 .. ptr_i+N_REQ modulo N_REQ, keep the first hit
  always_comb begin
    win_oh_o  = {N_REQ{1'b0}};
    win_idx_o = {IDX_W{1'b0}};
    win_vld_o = 1'b0;
    cand      = 0;
    hit       = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(ptr_i) + k;
      cand = (cand >= N_REQ) ? (cand - N_REQ) : cand;
      for (int j = 0; j < N_REQ; j++) begin
        hit         = !win_vld_o && req_i[j] && (j == cand);
        win_oh_o[j] = win_oh_o[j] | hit;
        win_idx_o   = hit ? IDX_W'(j) : win_idx_o;
        win_vld_o   = win_vld_o | hit;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one MAC TX byte port between N_REQ FWFT queues.
// Define TX_ARB_STATS_EN to build the per-requester completed-frame counters.
module mac_tx_arbiter
  import mac_tx_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DATA_W     = 8,
  parameter int IFG_CYCLES = IFG_CYCLES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ*DATA_W-1:0]      req_data,
  input  logic [N_REQ-1:0]             req_empty,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_read,
  output logic [N_REQ-1:0]             req_abort,
  output logic [DATA_W-1:0]            mac_tx_data,
  output logic                         mac_tx_dvld,
  input  logic                         mac_tx_ack,
  input  logic                         mac_tx_underrun,
  output logic [N_REQ-1:0]             grant,
  output logic                         busy,
  output logic [N_REQ*FRAME_CNT_W-1:0] frame_cnt
);

  localparam int         IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] GAP_LOAD = 8'(IFG_CYCLES - 1);

  tx_state_e        state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       gap_q, gap_d;

  logic [N_REQ-1:0] pick_oh_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_vld_s;
  logic             g_last_s;

  tx_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i     (~req_empty),
    .ptr_i     (rr_ptr_q),
    .win_oh_o  (pick_oh_s),
    .win_idx_o (pick_idx_s),
    .win_vld_o (pick_vld_s)
  );

  assign g_last_s = |(req_last & grant_q);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= {N_REQ{1'b0}};
      rr_ptr_q <= IDX_W'(N_REQ - 1);
      gap_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      gap_q    <= gap_d;
    end
  end

  // next-state: underrun preempts ack and req_last in both active states
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    gap_d    = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s) begin
          grant_d  = pick_oh_s;
          rr_ptr_d = pick_idx_s;
          state_d  = ST_BEGIN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_BEGIN, ST_SEND: begin
        if (mac_tx_underrun || (g_last_s && (mac_tx_ack || (state_q == ST_SEND)))) begin
          state_d = ST_GAP;
          grant_d = {N_REQ{1'b0}};
          gap_d   = GAP_LOAD;
        end else if (mac_tx_ack || (state_q == ST_SEND)) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_BEGIN;
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d   = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {N_REQ{1'b0}};
      end
    endcase
  end

  // outputs: handshake strobes and byte mux of the owning queue
  always_comb begin
    mac_tx_dvld = (state_q == ST_BEGIN) || (state_q == ST_SEND);
    req_read    = {N_REQ{1'b0}};
    req_abort   = {N_REQ{1'b0}};
    mac_tx_data = {DATA_W{1'b0}};
    if (mac_tx_dvld && mac_tx_underrun) begin
      req_abort = grant_q;
    end else if ((state_q == ST_SEND) || ((state_q == ST_BEGIN) && mac_tx_ack)) begin
      req_read  = grant_q;
    end else begin
      req_read  = {N_REQ{1'b0}};
    end
    for (int i = 0; i < N_REQ; i++) begin
      mac_tx_data = mac_tx_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

`ifdef TX_ARB_STATS_EN
  logic                   frame_done_s;
  logic [FRAME_CNT_W-1:0] cnt_q [N_REQ];

  assign frame_done_s = !mac_tx_underrun && g_last_s &&
                        ((state_q == ST_SEND) || ((state_q == ST_BEGIN) && mac_tx_ack));

  // completed-frame counters, wrap naturally at the counter width
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) begin
        cnt_q[i] <= {FRAME_CNT_W{1'b0}};
      end else if (frame_done_s && grant_q[i]) begin
        cnt_q[i] <= cnt_q[i] + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_q[i] <= cnt_q[i];
      end
    end
  end

  always_comb begin
    frame_cnt = {(N_REQ*FRAME_CNT_W){1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      frame_cnt[i*FRAME_CNT_W +: FRAME_CNT_W] = cnt_q[i];
    end
  end
`else
  assign frame_cnt = {(N_REQ*FRAME_CNT_W){1'b0}};
`endif

endmodule
